// File: rtl/rgb_pwm_driver_pkg.sv
// Shared definitions for the RGB PWM driver: mode encoding, blink FSM
// states and the LED enable rule.
package rgb_pkg;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_STEADY = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_BLINK_ON  = 2'b01,
    ST_BLINK_OFF = 2'b10
  } blink_state_e;

  // Steady mode always lights; blink lights only in its on half-phase.
  // Off and reserved modes never light.
  function automatic logic led_enable(input logic [1:0] mode, input blink_state_e state);
    return (mode == MODE_STEADY) || (state == ST_BLINK_ON);
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Colour/brightness request bus into the driver and LED drives back out.
interface rgb_pwm_driver_if #(
  parameter int PWM_W = 8
);

  logic             R;
  logic             G;
  logic             B;
  logic [PWM_W-1:0] duty;
  logic [1:0]       mode;
  logic             load;
  logic             led_r;
  logic             led_g;
  logic             led_b;
  logic             period_tick;

  modport master (
    output R, G, B, duty, mode, load,
    input  led_r, led_g, led_b, period_tick
  );

  modport slave (
    input  R, G, B, duty, mode, load,
    output led_r, led_g, led_b, period_tick
  );

endinterface

// File: rtl/rgb_pwm_driver_pwm_counter.sv
// Free-running PWM period counter. wrap flags the last count of a period;
// tick is the registered period-start pulse that follows it.
module pwm_counter #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PWM_W-1:0] cnt,
  output logic             wrap,
  output logic             tick
);

  assign wrap = (cnt == {PWM_W{1'b1}});

  // Count every clock; tick lands in the cycle where cnt has just returned to 0.
  // Reset leaves tick low so the first pulse comes a full period later.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= wrap;
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB PWM LED driver: pending/active settings, blink FSM and LED outputs.
// New settings only take effect at a period boundary so duty and colour
// never change mid-period.
//
//   state        | meaning
//   -------------+--------------------------------------------------
//   ST_IDLE      | not blinking (mode off, steady or reserved)
//   ST_BLINK_ON  | blink on half-phase, PWM drives LEDs
//   ST_BLINK_OFF | blink off half-phase, LEDs held low
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int PWM_W     = 8,
  parameter int BLINK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  rgb_pwm_driver_if.slave bus
);

  localparam logic [7:0] BCNT_LAST = 8'(BLINK_DIV - 1);

  logic [PWM_W-1:0] cnt;
  logic             wrap;
  logic             tick;

  logic [2:0]       in_rgb;
  logic [2:0]       pend_rgb;
  logic [PWM_W-1:0] pend_duty;
  logic [1:0]       pend_mode;
  logic             pend_valid;

  logic [2:0]       act_rgb;
  logic [PWM_W-1:0] act_duty;
  logic [1:0]       act_mode;

  logic [2:0]       nxt_rgb;
  logic [PWM_W-1:0] nxt_duty;
  logic [1:0]       nxt_mode;

  blink_state_e     state;
  logic [7:0]       bcnt;
  logic             en;
  logic             led_r_q;
  logic             led_g_q;
  logic             led_b_q;

  pwm_counter #(.PWM_W(PWM_W)) u_pwm_counter (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .wrap (wrap),
    .tick (tick)
  );

  assign in_rgb = {bus.R, bus.G, bus.B};

  // Settings installed at the next wrap: a load in the wrap cycle itself
  // beats anything pending, otherwise pending wins over keeping the old set.
  always_comb begin
    nxt_rgb  = act_rgb;
    nxt_duty = act_duty;
    nxt_mode = act_mode;
    if (bus.load) begin
      nxt_rgb  = in_rgb;
      nxt_duty = bus.duty;
      nxt_mode = bus.mode;
    end else if (pend_valid) begin
      nxt_rgb  = pend_rgb;
      nxt_duty = pend_duty;
      nxt_mode = pend_mode;
    end
  end

  // Pending register: last load before the wrap wins; consumed at the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_rgb   <= '0;
      pend_duty  <= '0;
      pend_mode  <= MODE_OFF;
      pend_valid <= 1'b0;
    end else if (wrap) begin
      pend_valid <= 1'b0;
    end else if (bus.load) begin
      pend_rgb   <= in_rgb;
      pend_duty  <= bus.duty;
      pend_mode  <= bus.mode;
      pend_valid <= 1'b1;
    end
  end

  // Active set changes only on the period boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_rgb  <= '0;
      act_duty <= '0;
      act_mode <= MODE_OFF;
    end else if (wrap) begin
      act_rgb  <= nxt_rgb;
      act_duty <= nxt_duty;
      act_mode <= nxt_mode;
    end
  end

  // Blink FSM advances once per period, judged against the mode being installed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      bcnt  <= '0;
    end else if (wrap) begin
      if (nxt_mode != MODE_BLINK) begin
        state <= ST_IDLE;
        bcnt  <= '0;
      end else if (state == ST_IDLE) begin
        state <= ST_BLINK_ON;
        bcnt  <= '0;
      end else if (bcnt == BCNT_LAST) begin
        state <= (state == ST_BLINK_ON) ? ST_BLINK_OFF : ST_BLINK_ON;
        bcnt  <= '0;
      end else begin
        bcnt  <= bcnt + 8'd1;
      end
    end
  end

  assign en = led_enable(act_mode, state);

  // LED drives lag cnt by one clock; duty of all-ones still leaves one low clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r_q <= 1'b0;
      led_g_q <= 1'b0;
      led_b_q <= 1'b0;
    end else begin
      led_r_q <= act_rgb[2] & en & (cnt < act_duty);
      led_g_q <= act_rgb[1] & en & (cnt < act_duty);
      led_b_q <= act_rgb[0] & en & (cnt < act_duty);
    end
  end

  assign bus.led_r       = led_r_q;
  assign bus.led_g       = led_g_q;
  assign bus.led_b       = led_b_q;
  assign bus.period_tick = tick;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver with PWM_W=8, BLINK_DIV=2. A period-level model
// (phase within period, blink decided by periods elapsed since blink start)
// predicts every output each cycle; scenario tasks add per-period counts.
module tb_rgb_pwm_driver;

  localparam int PWM_W     = 8;
  localparam int BLINK_DIV = 2;
  localparam int PERIOD    = 1 << PWM_W;

  logic clk = 1'b0;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  rgb_pwm_driver_if #(.PWM_W(PWM_W)) bus ();

  rgb_pwm_driver #(.PWM_W(PWM_W), .BLINK_DIV(BLINK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         m_phase   = 0;
  logic [2:0] m_rgb     = '0;
  logic [7:0] m_duty    = '0;
  logic [1:0] m_mode    = '0;
  logic [2:0] p_rgb     = '0;
  logic [7:0] p_duty    = '0;
  logic [1:0] p_mode    = '0;
  logic       m_pv      = 1'b0;
  logic       m_inblink = 1'b0;
  int         m_bp      = 0;

  task automatic step();
    int         ph;
    logic       en;
    logic [2:0] exp_led;
    logic       exp_tick;
    ph = m_phase;
    en = (m_mode == 2'b01) || (m_inblink && (((m_bp / BLINK_DIV) % 2) == 0));
    @(posedge clk);
    #1;
    if (rst) begin
      exp_led = '0; exp_tick = 1'b0;
      m_phase = 0; m_rgb = '0; m_duty = '0; m_mode = '0;
      p_rgb = '0; p_duty = '0; p_mode = '0; m_pv = 1'b0;
      m_inblink = 1'b0; m_bp = 0;
    end else begin
      exp_led  = (en && ph < int'(m_duty)) ? m_rgb : 3'b000;
      exp_tick = (ph == PERIOD - 1);
      if (ph == PERIOD - 1) begin
        if (bus.load) begin
          m_rgb = {bus.R, bus.G, bus.B}; m_duty = bus.duty; m_mode = bus.mode;
        end else if (m_pv) begin
          m_rgb = p_rgb; m_duty = p_duty; m_mode = p_mode;
        end
        m_pv = 1'b0;
        if (m_mode == 2'b10) begin
          if (m_inblink) m_bp++;
          else begin m_inblink = 1'b1; m_bp = 0; end
        end else begin
          m_inblink = 1'b0;
        end
      end else if (bus.load) begin
        p_rgb = {bus.R, bus.G, bus.B}; p_duty = bus.duty; p_mode = bus.mode; m_pv = 1'b1;
      end
      m_phase = (ph + 1) % PERIOD;
    end
    vectors++;
    if ({bus.led_r, bus.led_g, bus.led_b, bus.period_tick} !== {exp_led, exp_tick}) begin
      miscompares++;
      $display("FAIL cycle t=%0t phase=%0d leds/tick got %b expected %b", $time, ph,
               {bus.led_r, bus.led_g, bus.led_b, bus.period_tick}, {exp_led, exp_tick});
    end
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (m_phase != p && n < 2 * PERIOD) begin
      step();
      n++;
    end
    if (m_phase != p) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_phase timeout: phase %0d required %0d", m_phase, p);
    end
  endtask

  task automatic do_load(input logic [2:0] rgb, input logic [7:0] d, input logic [1:0] md);
    {bus.R, bus.G, bus.B} = rgb;
    bus.duty = d;
    bus.mode = md;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  // Counts high samples per LED over one full period (samples 1..256 after phase 0),
  // optionally asserting a load while cnt == load_ph.
  task automatic count_period(input int load_ph, input logic [2:0] rgb, input logic [7:0] d,
                              input logic [1:0] md, output int nr, output int ng, output int nb);
    nr = 0; ng = 0; nb = 0;
    wait_phase(0);
    for (int i = 0; i < PERIOD; i++) begin
      if (i == load_ph) begin
        {bus.R, bus.G, bus.B} = rgb;
        bus.duty = d;
        bus.mode = md;
        bus.load = 1'b1;
      end
      step();
      bus.load = 1'b0;
      nr += int'(bus.led_r); ng += int'(bus.led_g); nb += int'(bus.led_b);
    end
  endtask

  task automatic check_counts(input string name, input int nr, input int ng, input int nb,
                              input int er, input int eg, input int eb);
    vectors++;
    if (nr != er || ng != eg || nb != eb) begin
      miscompares++;
      $display("FAIL %s: high counts r/g/b got %0d/%0d/%0d expected %0d/%0d/%0d",
               name, nr, ng, nb, er, eg, eb);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    logic found = 1'b0;
    rst = 1'b1;
    bus.load = 1'b1; {bus.R, bus.G, bus.B} = 3'b111; bus.duty = 8'd200; bus.mode = 2'b01;
    repeat (3) step();
    rst = 1'b0;
    bus.load = 1'b0;
    while (!found && n < PERIOD + 50) begin
      step();
      n++;
      if (bus.period_tick === 1'b1) found = 1'b1;
    end
    vectors++;
    if (!found || n != PERIOD) begin
      miscompares++;
      $display("FAIL reset_first_tick: got tick after %0d cycles (seen=%0b) expected %0d", n, found, PERIOD);
    end
  endtask

  task automatic test_steady();
    int nr, ng, nb;
    wait_phase(10);
    do_load(3'b100, 8'd64, 2'b01);
    count_period(-1, 3'b000, 8'd0, 2'b00, nr, ng, nb);
    check_counts("steady_64", nr, ng, nb, 64, 0, 0);
  endtask

  task automatic test_bounds();
    int nr, ng, nb;
    count_period(50, 3'b111, 8'd0, 2'b01, nr, ng, nb);
    count_period(-1, 3'b000, 8'd0, 2'b00, nr, ng, nb);
    check_counts("duty_0", nr, ng, nb, 0, 0, 0);
    count_period(50, 3'b111, 8'd255, 2'b01, nr, ng, nb);
    count_period(-1, 3'b000, 8'd0, 2'b00, nr, ng, nb);
    check_counts("duty_255", nr, ng, nb, 255, 255, 255);
  endtask

  task automatic test_mid_period();
    int nr, ng, nb;
    count_period(20, 3'b100, 8'd64, 2'b01, nr, ng, nb);
    count_period(30, 3'b100, 8'd128, 2'b01, nr, ng, nb);
    check_counts("mid_keep_64", nr, ng, nb, 64, 0, 0);
    count_period(40, 3'b100, 8'd200, 2'b01, nr, ng, nb);
    check_counts("mid_then_128", nr, ng, nb, 128, 0, 0);
    count_period(-1, 3'b000, 8'd0, 2'b00, nr, ng, nb);
    check_counts("mid_then_200", nr, ng, nb, 200, 0, 0);
  endtask

  task automatic test_blink();
    int nr, ng, nb;
    int e;
    count_period(100, 3'b111, 8'd255, 2'b10, nr, ng, nb);
    check_counts("blink_prev_period", nr, ng, nb, 200, 0, 0);
    for (int k = 0; k < 6; k++) begin
      e = (((k / BLINK_DIV) % 2) == 0) ? 255 : 0;
      count_period(-1, 3'b000, 8'd0, 2'b00, nr, ng, nb);
      check_counts($sformatf("blink_period_%0d", k), nr, ng, nb, e, e, e);
    end
    // Blink period index 6 is an off phase; the load sits on its wrap cycle.
    count_period(PERIOD - 1, 3'b010, 8'd10, 2'b01, nr, ng, nb);
    check_counts("blink_period_6", nr, ng, nb, 0, 0, 0);
    count_period(-1, 3'b000, 8'd0, 2'b00, nr, ng, nb);
    check_counts("wrap_coincident_load", nr, ng, nb, 0, 10, 0);
  endtask

  task automatic test_reset_mid_blink();
    int on = 0;
    int ticks = 0;
    wait_phase(5);
    do_load(3'b111, 8'd255, 2'b10);
    wait_phase(60);
    do_load(3'b100, 8'd77, 2'b01);
    wait_phase(80);
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({bus.led_r, bus.led_g, bus.led_b} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_mid_blink_leds: got %b expected 000", {bus.led_r, bus.led_g, bus.led_b});
    end
    for (int i = 0; i < 2 * PERIOD; i++) begin
      step();
      on += int'(bus.led_r) + int'(bus.led_g) + int'(bus.led_b);
      ticks += int'(bus.period_tick);
    end
    vectors++;
    if (on != 0 || ticks != 2) begin
      miscompares++;
      $display("FAIL rst_mid_blink_after: led highs %0d ticks %0d expected 0 and 2", on, ticks);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        case ($urandom_range(0, 3))
          0:       d = 8'd0;
          1:       d = 8'd255;
          default: d = 8'($urandom_range(0, 255));
        endcase
        {bus.R, bus.G, bus.B} = 3'($urandom_range(0, 7));
        bus.duty = d;
        bus.mode = 2'($urandom_range(0, 3));
        bus.load = 1'b1;
      end
      rst = ($urandom_range(0, 999) == 0);
      step();
      bus.load = 1'b0;
      rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.load = 1'b0;
    bus.R = 1'b0; bus.G = 1'b0; bus.B = 1'b0;
    bus.duty = '0;
    bus.mode = 2'b00;
    test_reset();
    test_steady();
    test_bounds();
    test_mid_period();
    test_blink();
    test_reset_mid_blink();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
